// File: rtl/csa_accum_pkg.sv
// Shared state encoding and width helper for the csa_accum_ctrl accumulator.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_e;

  // Guard bits needed so a full frame of MAX_OPS operands cannot wrap.
  function automatic int guard_width(input int max_ops);
    return $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Operand-in / result-out stream bundle for csa_accum_ctrl.
// Carries out_ovf only when CSA_ACCUM_OVF_EN is defined.
interface csa_accum_ctrl_if #(
  parameter int K     = 64,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [K-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
`ifdef CSA_ACCUM_OVF_EN
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
`endif
endinterface

// File: rtl/csa_accum_ctrl_csa_3to2.sv
// Bitwise 3:2 carry-save compressor; carries are weighted one bit up and the top carry is dropped.
module csa_3to2 #(
  parameter int N = 3,
  parameter int W = 64
) (
  input  logic [N-1:0][W-1:0] ops_i,
  output logic [W-1:0]        s_o,
  output logic [W-1:0]        c_o
);
  logic [W-1:0] maj_d;

  assign s_o   = ops_i[0] ^ ops_i[1] ^ ops_i[2];
  assign maj_d = (ops_i[0] & ops_i[1]) | (ops_i[0] & ops_i[2]) | (ops_i[1] & ops_i[2]);
  assign c_o   = maj_d << 1;
endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: running sum kept in carry-save form, resolved once per frame.
// Define CSA_ACCUM_OVF_EN to widen the internal sum by guard bits and report out_ovf.
module csa_accum_ctrl
  import csa_accum_pkg::*;
#(
  parameter int  K       = 64,
  parameter int  MAX_OPS = 16,
  localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input logic              clk,
  input logic              rst,
  csa_accum_ctrl_if.slave  bus
);
`ifdef CSA_ACCUM_OVF_EN
  localparam int W = K + guard_width(MAX_OPS);
`else
  localparam int W = K;
`endif

  state_e           state_q;
  logic [W-1:0]     sum_q, carry_q;
  logic [W-1:0]     sum_d, carry_d, operand_d, resolved_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [K-1:0]     out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             in_ready_q, out_valid_q;
  logic             in_hs_d, out_hs_d, frame_end_d;
  logic [2:0][W-1:0] csa_in_d;
`ifdef CSA_ACCUM_OVF_EN
  logic             out_ovf_q;
`endif

  assign operand_d   = W'(bus.in_data);
  assign csa_in_d    = {operand_d, carry_q, sum_q};
  assign in_hs_d     = bus.in_valid & in_ready_q;
  assign out_hs_d    = bus.out_ready & out_valid_q;
  assign count_d     = count_q + CNT_W'(1);
  assign frame_end_d = bus.in_last | (count_d == CNT_W'(MAX_OPS));
  assign resolved_d  = sum_q + carry_q;

  csa_3to2 #(.N(3), .W(W)) u_csa (
    .ops_i (csa_in_d),
    .s_o   (sum_d),
    .c_o   (carry_d)
  );

  // Frame FSM: fold operands in ACC, resolve once, hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      sum_q       <= '0;
      carry_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CSA_ACCUM_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACC: begin
          if (in_hs_d) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            if (frame_end_d) begin
              state_q    <= RESOLVE;
              in_ready_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_data_q  <= resolved_d[K-1:0];
          out_count_q <= count_q;
`ifdef CSA_ACCUM_OVF_EN
          out_ovf_q   <= |(resolved_d >> K);
`endif
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_hs_d) begin
            sum_q       <= '0;
            carry_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACC;
          end
        end
        default: begin
          state_q     <= ACC;
          sum_q       <= '0;
          carry_q     <= '0;
          count_q     <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
`ifdef CSA_ACCUM_OVF_EN
  assign bus.out_ovf   = out_ovf_q;
`endif
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl at K=8, MAX_OPS=4: table of frames plus corner-case sequences.
module tb_csa_accum_ctrl;
  localparam int K       = 8;
  localparam int MAX_OPS = 4;
  localparam int CNT_W   = 3;

  typedef struct {
    int               n;
    logic [3:0][K-1:0] ops;
    logic [K-1:0]     exp_data;
    logic [CNT_W-1:0] exp_count;
    logic             exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [6];
  logic [K-1:0] rvals [4];

  always #5 clk = ~clk;

  csa_accum_ctrl_if #(.K(K), .CNT_W(CNT_W)) bus ();

  csa_accum_ctrl #(.K(K), .MAX_OPS(MAX_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input int n, input logic [3:0][K-1:0] ops,
                         input logic [K-1:0] d, input logic [CNT_W-1:0] c, input logic o);
    vecs[idx].n         = n;
    vecs[idx].ops       = ops;
    vecs[idx].exp_data  = d;
    vecs[idx].exp_count = c;
    vecs[idx].exp_ovf   = o;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.ops[i];
      bus.in_last  = (i == v.n - 1);
      check("acc_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    // Cycle after the last handshake is RESOLVE; out_valid appears one cycle later.
    check("resolve_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("resolve_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("out_data", {24'd0, bus.out_data}, {24'd0, v.exp_data});
    check("out_count", {29'd0, bus.out_count}, {29'd0, v.exp_count});
`ifdef CSA_ACCUM_OVF_EN
    check("out_ovf", {31'd0, bus.out_ovf}, {31'd0, v.exp_ovf});
`endif
    take_result();
  endtask

  initial begin
    vec_t one;
    int   idx;
    int   guard;
    logic v;
    logic acc;

    set_vec(0, 3, {8'd0, 8'd50, 8'd100, 8'd200}, 8'd94, 3'd3, 1'b1);
    set_vec(1, 1, {8'd0, 8'd0, 8'd0, 8'hFF}, 8'hFF, 3'd1, 1'b0);
    set_vec(2, 3, {8'd0, 8'd3, 8'd2, 8'd1}, 8'd6, 3'd3, 1'b0);
    set_vec(3, 4, {8'd8, 8'd7, 8'd6, 8'd5}, 8'd26, 3'd4, 1'b0);
    set_vec(4, 2, {8'd0, 8'd0, 8'h80, 8'h80}, 8'd0, 3'd2, 1'b1);
    set_vec(5, 4, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'd252, 3'd4, 1'b1);
    rvals[0] = 8'd5; rvals[1] = 8'd6; rvals[2] = 8'd7; rvals[3] = 8'd8;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_count", {29'd0, bus.out_count}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low, offered beat waits.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i + 1);
      bus.in_last  = (i == 2);
      tick();
    end
    bus.in_data = 8'd9;
    bus.in_last = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_data", {24'd0, bus.out_data}, 32'd6);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    check("bp_out_count", {29'd0, bus.out_count}, 32'd3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_next_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_next_resolve", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("bp_next_data", {24'd0, bus.out_data}, 32'd9);
    check("bp_next_count", {29'd0, bus.out_count}, 32'd1);
    take_result();

    // Forced termination at MAX_OPS: five beats of 1 with no in_last.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("max_resolve_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("max_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("max_out_data", {24'd0, bus.out_data}, 32'd4);
    check("max_out_count", {29'd0, bus.out_count}, 32'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    bus.in_data = 8'd10;
    bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check("max_next_data", {24'd0, bus.out_data}, 32'd11);
    check("max_next_count", {29'd0, bus.out_count}, 32'd2);
    take_result();

    // Asynchronous reset mid-frame discards the partial sum.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd10;
    tick();
    bus.in_data = 8'd20;
    tick();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("async_rst_out_count", {29'd0, bus.out_count}, 32'd0);
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    one.n = 1;
    one.ops = {8'd0, 8'd0, 8'd0, 8'd7};
    one.exp_data = 8'd7;
    one.exp_count = 3'd1;
    one.exp_ovf = 1'b0;
    run_vec(one);

    // Random in_valid gaps; idle cycles carry junk data and in_last=1, which must be ignored.
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      v = 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = v ? rvals[idx] : 8'hAA;
      bus.in_last  = v ? (idx == 3) : 1'b1;
      acc = v & bus.in_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("rand_beats_sent", idx, 32'd4);
    tick();
    check("rand_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("rand_out_data", {24'd0, bus.out_data}, 32'd26);
    check("rand_out_count", {29'd0, bus.out_count}, 32'd4);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
